// File: rtl/ibex_tr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : ibex_tr_mem_responder (+ helper ibex_tr_mem_responder_chan)
// Purpose  : Dual-channel (instr/data) word-addressed memory responder for
//            the Ibex testrig top. Configurable grant delay, response latency
//            and outstanding-request limit per channel.
// Option   : TESTRIG_MEM_ERR_INJECT_EN adds address-targeted error injection.
// Revision : 1.0 - initial release
// ============================================================================

// One request/grant/rvalid channel: grant control, outstanding counter and
// the fixed-latency response pipeline. Memory access is done by the parent.
module ibex_tr_mem_responder_chan #(
  parameter int GntDelay       = 0,
  parameter int RspLatency     = 1,
  parameter int MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        i_req,
  input  logic [31:0] i_rdata,
  input  logic        i_err,
  output logic        o_gnt,
  output logic        o_accept,
  output logic        o_rvalid,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  localparam logic [3:0] c_MAX_OUT = 4'(MaxOutstanding);

  logic        w_room;
  logic        w_gnt;
  logic [3:0]  r_out;
  logic        r_vld [RspLatency];
  logic [31:0] r_dat [RspLatency];
  logic        r_err [RspLatency];

  assign w_room   = (r_out < c_MAX_OUT);
  assign o_gnt    = w_gnt;
  assign o_accept = w_gnt;
  assign o_rvalid = r_vld[RspLatency-1];
  assign o_rdata  = r_dat[RspLatency-1];
  assign o_err    = r_err[RspLatency-1];

  generate
    if (GntDelay == 0) begin : g_nodelay
      // Zero-delay grant is purely combinational; reset forces it low.
      assign w_gnt = rst_ni && i_req && w_room;
    end else begin : g_delay
      localparam logic [1:0] c_IDLE  = 2'd0;
      localparam logic [1:0] c_WAIT  = 2'd1;
      localparam logic [1:0] c_GRANT = 2'd2;
      localparam logic [3:0] c_DELAY = 4'(GntDelay);

      logic [1:0] r_state;
      logic [3:0] r_cnt;

      assign w_gnt = rst_ni && i_req && (r_state == c_GRANT) && w_room;

      // Count cycles req is held; park in GRANT (holding the count) until accepted.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_state <= c_IDLE;
          r_cnt   <= '0;
        end else if (!i_req || w_gnt) begin
          r_state <= c_IDLE;
          r_cnt   <= '0;
        end else if (r_state != c_GRANT) begin
          r_cnt   <= r_cnt + 4'd1;
          r_state <= ((r_cnt + 4'd1) == c_DELAY) ? c_GRANT : c_WAIT;
        end
      end
    end
  endgenerate

  // Response shift pipeline; data/err stay 0 in empty slots so outputs are 0 off-rvalid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RspLatency; i++) begin
        r_vld[i] <= 1'b0;
        r_dat[i] <= '0;
        r_err[i] <= 1'b0;
      end
    end else begin
      r_vld[0] <= w_gnt;
      r_dat[0] <= w_gnt ? i_rdata : '0;
      r_err[0] <= w_gnt && i_err;
      for (int i = 1; i < RspLatency; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_dat[i] <= r_dat[i-1];
        r_err[i] <= r_err[i-1];
      end
    end
  end

  // Outstanding = accepted but not yet answered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out <= '0;
    end else begin
      r_out <= r_out + {3'b000, w_gnt} - {3'b000, o_rvalid};
    end
  end

endmodule

module ibex_tr_mem_responder #(
  parameter int          Depth          = 16384,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int          GntDelay       = 0,
  parameter int          RspLatency     = 1,
  parameter int          MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
`ifdef TESTRIG_MEM_ERR_INJECT_EN
  ,
  input  logic        err_inject_en_i,
  input  logic [31:0] err_inject_addr_i,
  input  logic        err_inject_chan_i
`endif
);

  localparam int c_AW = $clog2(Depth);

  // Shared store; no reset so contents survive rst_ni.
  logic [31:0] r_mem [Depth];

  logic [31:0]     w_i_off, w_d_off;
  logic [c_AW-1:0] w_i_idx, w_d_idx;
  logic            w_i_inj, w_d_inj;
  logic            w_i_err, w_d_err;
  logic [31:0]     w_i_rdata, w_d_rdata;
  logic            w_i_acc, w_d_acc;
  logic            w_unused;

  // Offset from base; addresses below base wrap high and fail the range test.
  assign w_i_off = instr_addr_i - BaseAddr;
  assign w_d_off = data_addr_i - BaseAddr;
  assign w_i_idx = w_i_off[c_AW+1:2];
  assign w_d_idx = w_d_off[c_AW+1:2];

`ifdef TESTRIG_MEM_ERR_INJECT_EN
  assign w_i_inj  = err_inject_en_i && !err_inject_chan_i &&
                    (instr_addr_i[31:2] == err_inject_addr_i[31:2]);
  assign w_d_inj  = err_inject_en_i && err_inject_chan_i &&
                    (data_addr_i[31:2] == err_inject_addr_i[31:2]);
  assign w_unused = ^{w_i_off[1:0], w_d_off[1:0], w_i_acc, err_inject_addr_i[1:0]};
`else
  assign w_i_inj  = 1'b0;
  assign w_d_inj  = 1'b0;
  assign w_unused = ^{w_i_off[1:0], w_d_off[1:0], w_i_acc};
`endif

  assign w_i_err = (w_i_off[31:2] >= 30'(Depth)) || w_i_inj;
  assign w_d_err = (w_d_off[31:2] >= 30'(Depth)) || w_d_inj;

  // Reads sample the store before this edge's write: read-before-write.
  assign w_i_rdata = w_i_err ? '0 : r_mem[w_i_idx];
  assign w_d_rdata = (w_d_err || data_we_i) ? '0 : r_mem[w_d_idx];

  ibex_tr_mem_responder_chan #(
    .GntDelay      (GntDelay),
    .RspLatency    (RspLatency),
    .MaxOutstanding(MaxOutstanding)
  ) u_instr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_req   (instr_req_i),
    .i_rdata (w_i_rdata),
    .i_err   (w_i_err),
    .o_gnt   (instr_gnt_o),
    .o_accept(w_i_acc),
    .o_rvalid(instr_rvalid_o),
    .o_rdata (instr_rdata_o),
    .o_err   (instr_err_o)
  );

  ibex_tr_mem_responder_chan #(
    .GntDelay      (GntDelay),
    .RspLatency    (RspLatency),
    .MaxOutstanding(MaxOutstanding)
  ) u_data (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_req   (data_req_i),
    .i_rdata (w_d_rdata),
    .i_err   (w_d_err),
    .o_gnt   (data_gnt_o),
    .o_accept(w_d_acc),
    .o_rvalid(data_rvalid_o),
    .o_rdata (data_rdata_o),
    .o_err   (data_err_o)
  );

  // Byte-masked write port; errored (out-of-range/injected) writes are dropped.
  always_ff @(posedge clk_i) begin
    if (w_d_acc && data_we_i && !w_d_err) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) r_mem[w_d_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ibex_tr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_tr_mem_responder
// Purpose  : Self-checking bench for ibex_tr_mem_responder. Three instances:
//            0 = defaults, 1 = GntDelay 3 / RspLatency 4, 2 = RspLatency 4
//            (outstanding limit reachable). Honours TESTRIG_MEM_ERR_INJECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibex_tr_mem_responder;

  localparam int N = 3;

  function automatic int gd(input int k);
    return (k == 1) ? 3 : 0;
  endfunction
  function automatic int lat(input int k);
    return (k == 0) ? 1 : 4;
  endfunction
  function automatic int mxo(input int k);
    return (k < 0) ? 1 : 2;
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ireq [N];
  logic [31:0] iaddr[N];
  logic        dreq [N];
  logic        dwe  [N];
  logic [3:0]  dbe  [N];
  logic [31:0] daddr[N];
  logic [31:0] dwd  [N];
  logic        igt[N], irv[N], ier[N], dgt[N], drv[N], der[N];
  logic [31:0] ird[N], drd[N];
`ifdef TESTRIG_MEM_ERR_INJECT_EN
  logic        inj_en   = 1'b0;
  logic [31:0] inj_addr = 32'h0;
  logic        inj_chan = 1'b0;
`endif

  for (genvar k = 0; k < N; k++) begin : g_dut
    ibex_tr_mem_responder #(
      .Depth(16384), .BaseAddr(32'h0), .GntDelay(gd(k)),
      .RspLatency(lat(k)), .MaxOutstanding(mxo(k))
    ) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .instr_req_i(ireq[k]), .instr_gnt_o(igt[k]), .instr_addr_i(iaddr[k]),
      .instr_rvalid_o(irv[k]), .instr_rdata_o(ird[k]), .instr_err_o(ier[k]),
      .data_req_i(dreq[k]), .data_gnt_o(dgt[k]), .data_we_i(dwe[k]),
      .data_be_i(dbe[k]), .data_addr_i(daddr[k]), .data_wdata_i(dwd[k]),
      .data_rvalid_o(drv[k]), .data_rdata_o(drd[k]), .data_err_o(der[k])
`ifdef TESTRIG_MEM_ERR_INJECT_EN
      , .err_inject_en_i(inj_en), .err_inject_addr_i(inj_addr), .err_inject_chan_i(inj_chan)
`endif
    );
  end

  // Reference model: expected responses per (dut, channel) with due cycle.
  typedef struct { int due; logic [31:0] d; logic e; } rsp_t;
  rsp_t        sb [2*N][$];
  bit   [31:0] mmem [N][16384];
  int          wcnt [2*N];
  bit          expg [2*N];
  bit          obsg [2*N];
  bit          obsv [2*N];
  logic [31:0] last_d [2*N];
  logic        last_e [2*N];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return a < 32'h0001_0000;
  endfunction

  function automatic bit inj_hit(input int ch, input logic [31:0] a);
`ifdef TESTRIG_MEM_ERR_INJECT_EN
    logic [31:0] t;
    t = inj_addr;
    return inj_en && (inj_chan == (ch == 1)) && (a[31:2] == t[31:2]);
`else
    return (ch < 0) && (a == 32'h0);
`endif
  endfunction

  // One clock cycle: called at negedge with inputs applied; checks, then updates model.
  task automatic tick();
    #1;
    if (!rst_n) begin
      for (int s = 0; s < 2*N; s++) begin
        sb[s].delete();
        wcnt[s] = 0;
      end
    end
    for (int k = 0; k < N; k++) begin
      for (int c = 0; c < 2; c++) begin
        int s;
        bit req, ev;
        logic [31:0] ed;
        logic ee;
        s   = 2*k + c;
        req = (c == 0) ? ireq[k] : dreq[k];
        expg[s] = rst_n && req && (wcnt[s] == gd(k)) && (sb[s].size() < mxo(k));
        ev = (sb[s].size() > 0) && (sb[s][0].due == cyc);
        ed = ev ? sb[s][0].d : 32'h0;
        ee = ev ? sb[s][0].e : 1'b0;
        obsg[s] = (c == 0) ? igt[k] : dgt[k];
        obsv[s] = (c == 0) ? irv[k] : drv[k];
        chk($sformatf("gnt d%0d c%0d cyc%0d", k, c, cyc), 32'(obsg[s]), 32'(expg[s]));
        chk($sformatf("rvalid d%0d c%0d cyc%0d", k, c, cyc), 32'(obsv[s]), 32'(ev));
        chk($sformatf("rdata d%0d c%0d cyc%0d", k, c, cyc), (c == 0) ? ird[k] : drd[k], ed);
        chk($sformatf("err d%0d c%0d cyc%0d", k, c, cyc), 32'((c == 0) ? ier[k] : der[k]), 32'(ee));
        if (obsv[s]) begin
          last_d[s] = (c == 0) ? ird[k] : drd[k];
          last_e[s] = (c == 0) ? ier[k] : der[k];
        end
      end
    end
    @(posedge clk);
    if (rst_n) begin
      for (int k = 0; k < N; k++) begin
        logic [31:0] a, d;
        logic e;
        for (int c = 0; c < 2; c++) begin
          if ((sb[2*k+c].size() > 0) && (sb[2*k+c][0].due == cyc)) void'(sb[2*k+c].pop_front());
        end
        if (expg[2*k]) begin
          a = iaddr[k];
          e = !in_range(a) || inj_hit(0, a);
          d = e ? 32'h0 : mmem[k][a[15:2]];
          sb[2*k].push_back('{due: cyc + lat(k), d: d, e: e});
        end
        if (expg[2*k+1]) begin
          a = daddr[k];
          e = !in_range(a) || inj_hit(1, a);
          d = (e || dwe[k]) ? 32'h0 : mmem[k][a[15:2]];
          sb[2*k+1].push_back('{due: cyc + lat(k), d: d, e: e});
          if (dwe[k] && !e) begin
            for (int b = 0; b < 4; b++)
              if (dbe[k][b]) mmem[k][a[15:2]][8*b +: 8] = dwd[k][8*b +: 8];
          end
        end
        for (int c = 0; c < 2; c++) begin
          bit req;
          req = (c == 0) ? ireq[k] : dreq[k];
          if (expg[2*k+c] || !req) wcnt[2*k+c] = 0;
          else if (wcnt[2*k+c] < gd(k)) wcnt[2*k+c]++;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  // Issue an instr and/or data request on instance k; hold each until accepted.
  task automatic txn(input int k, input bit di, input logic [31:0] ia,
                     input bit dd, input bit we, input logic [3:0] be,
                     input logic [31:0] da, input logic [31:0] wd, output int waited);
    ireq[k] = di; iaddr[k] = ia;
    dreq[k] = dd; dwe[k] = we; dbe[k] = be; daddr[k] = da; dwd[k] = wd;
    waited = 0;
    while ((ireq[k] || dreq[k]) && waited < 40) begin
      tick();
      waited++;
      if (expg[2*k])   ireq[k] = 1'b0;
      if (expg[2*k+1]) dreq[k] = 1'b0;
    end
    chk($sformatf("txn_accepted d%0d", k), 32'(ireq[k] | dreq[k]), 32'h0);
    ireq[k] = 1'b0;
    dreq[k] = 1'b0;
  endtask

  task automatic drain();
    int n, pend;
    n = 0;
    pend = 1;
    while (pend != 0 && n < 30) begin
      pend = 0;
      for (int s = 0; s < 2*N; s++) pend += sb[s].size();
      if (pend != 0) begin
        tick();
        n++;
      end
    end
    chk("drain_pending", 32'(pend), 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'h0001_0000 + 32'($urandom_range(0, 15));
    if (r == 1) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
    return 32'($urandom_range(0, 127));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, cnt;
    for (int k = 0; k < N; k++) begin
      ireq[k] = 0; iaddr[k] = 0; dreq[k] = 0; dwe[k] = 0;
      dbe[k] = 0; daddr[k] = 0; dwd[k] = 0;
    end
    for (int s = 0; s < 2*N; s++) begin
      last_d[s] = 32'h0;
      last_e[s] = 1'b0;
    end
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Write then read back; zero-delay grant lands in the request cycle.
    txn(0, 0, 0, 1, 1, 4'hF, 32'h100, 32'hDEADBEEF, w);
    drain();
    txn(0, 1, 32'h100, 0, 0, 4'h0, 0, 0, w);
    chk("gnt_same_cycle", 32'(w), 32'd1);
    drain();
    chk("tp1_rdata", last_d[0], 32'hDEADBEEF);
    chk("tp1_err", 32'(last_e[0]), 32'h0);

    // Byte enables.
    txn(0, 0, 0, 1, 1, 4'hF, 32'h104, 32'hAABBCCDD, w);
    txn(0, 0, 0, 1, 1, 4'b0101, 32'h104, 32'h11223344, w);
    drain();
    txn(0, 0, 0, 1, 0, 4'hF, 32'h104, 0, w);
    drain();
    chk("be_merge", last_d[1], 32'hAA22CC44);

    // Empty byte-enable write: no error, memory unchanged.
    txn(0, 0, 0, 1, 1, 4'h0, 32'h104, 32'hFFFFFFFF, w);
    drain();
    chk("be0_err", 32'(last_e[1]), 32'h0);
    chk("be0_wrdata", last_d[1], 32'h0);
    txn(0, 1, 32'h104, 0, 0, 4'h0, 0, 0, w);
    drain();
    chk("be0_unchanged", last_d[0], 32'hAA22CC44);

    // Out of range read and write; the write must not alias onto word 0.
    txn(0, 0, 0, 1, 0, 4'hF, 32'h0001_0000, 0, w);
    drain();
    chk("oor_rd_err", 32'(last_e[1]), 32'h1);
    chk("oor_rd_data", last_d[1], 32'h0);
    txn(0, 0, 0, 1, 1, 4'hF, 32'h0001_0000, 32'h12345678, w);
    drain();
    chk("oor_wr_err", 32'(last_e[1]), 32'h1);
    txn(0, 0, 0, 1, 0, 4'hF, 32'h0, 0, w);
    drain();
    chk("oor_no_alias", last_d[1], 32'h0);

    // Same-edge instr read and data write to one word.
    txn(0, 0, 0, 1, 1, 4'hF, 32'h40, 32'h7, w);
    drain();
    txn(0, 1, 32'h40, 1, 1, 4'hF, 32'h40, 32'h5, w);
    drain();
    chk("rbw_old", last_d[0], 32'h7);
    txn(0, 1, 32'h40, 0, 0, 4'h0, 0, 0, w);
    drain();
    chk("rbw_new", last_d[0], 32'h5);

    // Grant delay 3: continuous req grants every 4th cycle.
    ireq[1] = 1'b1; iaddr[1] = 32'h100;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      cnt += int'(obsg[2]);
    end
    ireq[1] = 1'b0;
    chk("gntdelay_count", 32'(cnt), 32'd4);
    drain();

    // Outstanding limit 2 with latency 4.
    ireq[2] = 1'b1; iaddr[2] = 32'h8;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      cnt += int'(obsg[4]);
    end
    ireq[2] = 1'b0;
    chk("limit_count", 32'(cnt), 32'd6);
    drain();

    // Reset mid-flight: outputs drop at once and the in-flight response vanishes.
    txn(2, 0, 0, 1, 0, 4'hF, 32'h100, 0, w);
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      cnt += int'(obsv[5]);
    end
    chk("rst_no_rvalid", 32'(cnt), 32'h0);
    txn(0, 1, 32'h100, 0, 0, 4'h0, 0, 0, w);
    drain();
    chk("rst_mem_kept", last_d[0], 32'hDEADBEEF);

`ifdef TESTRIG_MEM_ERR_INJECT_EN
    inj_en = 1'b1; inj_addr = 32'h200; inj_chan = 1'b1;
    txn(0, 0, 0, 1, 0, 4'hF, 32'h200, 0, w);
    drain();
    chk("inj_data_err", 32'(last_e[1]), 32'h1);
    txn(0, 1, 32'h200, 0, 0, 4'h0, 0, 0, w);
    drain();
    chk("inj_other_chan", 32'(last_e[0]), 32'h0);
    inj_en = 1'b0;
`endif

    // Randomized traffic on all instances against the model.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) begin
        ireq[k]  = ($urandom_range(0, 2) != 0);
        iaddr[k] = rand_addr();
        dreq[k]  = ($urandom_range(0, 2) != 0);
        dwe[k]   = $urandom_range(0, 1) != 0;
        dbe[k]   = 4'($urandom_range(0, 15));
        daddr[k] = rand_addr();
        dwd[k]   = $urandom;
      end
`ifdef TESTRIG_MEM_ERR_INJECT_EN
      inj_en   = ($urandom_range(0, 3) == 0);
      inj_addr = rand_addr();
      inj_chan = $urandom_range(0, 1) != 0;
`endif
      tick();
    end
    for (int k = 0; k < N; k++) begin
      ireq[k] = 1'b0;
      dreq[k] = 1'b0;
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
